// File: rtl/serial_frame_serializer.sv
// Parallel-to-serial frame stage: valid/ready word capture, one bit per clock on x.
// Define SERIAL_FRAME_PARITY_EN to append an even-parity bit to every frame.
module serial_frame_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef SERIAL_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             busy_q, busy_d;
`ifdef SERIAL_FRAME_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             handshake;

  assign din_ready   = reset & ((state_q == IDLE) | frame_end_q);
  assign handshake   = din_valid & din_ready;

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

  // x_q always holds the bit being presented; cnt_q is that bit's index in the word.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    x_valid_d     = x_valid_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    busy_d        = busy_q;
`ifdef SERIAL_FRAME_PARITY_EN
    par_d         = par_q;
`endif

    if (handshake) begin
      state_d   = SHIFT;
      cnt_d     = '0;
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
      frame_start_d = 1'b1;
      if (LSB_FIRST) begin
        x_d     = din[0];
        shreg_d = din >> 1;
      end else begin
        x_d     = din[WIDTH-1];
        shreg_d = din << 1;
      end
`ifdef SERIAL_FRAME_PARITY_EN
      par_d = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + 1'b1;
            if (LSB_FIRST) begin
              x_d     = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end else begin
              x_d     = shreg_q[WIDTH-1];
              shreg_d = shreg_q << 1;
            end
`ifndef SERIAL_FRAME_PARITY_EN
            frame_end_d = (cnt_q == PRE_LAST);
`endif
          end else begin
`ifdef SERIAL_FRAME_PARITY_EN
            state_d     = PAR;
            x_d         = par_q;
            frame_end_d = 1'b1;
`else
            state_d   = IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
`endif
          end
        end
        default: begin
          state_d   = IDLE;
          shreg_d   = '0;
          cnt_d     = '0;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
`ifdef SERIAL_FRAME_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_serializer.sv
// Bench for serial_frame_serializer: an LSB-first and an MSB-first instance against a frame-queue model.
module tb_serial_frame_serializer;

  localparam int W = 8;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NF = W + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] din0, din1;
  logic         v0, v1;
  logic [1:0]   rdy, xo, xv, fs, fe, bz;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_frame_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy[0]),
    .x(xo[0]), .x_valid(xv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0])
  );

  serial_frame_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy[1]),
    .x(xo[1]), .x_valid(xv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1])
  );

  // One expected output cycle of the serial stream.
  typedef struct packed {
    logic v;
    logic x;
    logic st;
    logic en;
  } ebit_t;

  ebit_t q0[$];
  ebit_t q1[$];
  ebit_t cur0, cur1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bit i of the result is the i-th bit sent on the wire.
  function automatic logic [W-1:0] frame_word(input logic [W-1:0] w, input bit lsb);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = lsb ? w[i] : w[W-1-i];
    return r;
  endfunction

  function automatic logic par_of(input logic [W-1:0] w);
    logic p = 1'b0;
    for (int i = 0; i < W; i++) p = p ^ w[i];
    return p;
  endfunction

  task automatic push_frame(input int k, input logic [W-1:0] w, input bit lsb);
    logic [W-1:0] s;
    ebit_t b;
    s = frame_word(w, lsb);
    for (int i = 0; i < W; i++) begin
      b.v  = 1'b1;
      b.x  = s[i];
      b.st = (i == 0);
      b.en = (PAR == 0) && (i == W - 1);
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
    if (PAR != 0) begin
      b.v  = 1'b1;
      b.x  = par_of(w);
      b.st = 1'b0;
      b.en = 1'b1;
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Model: an accepted word appends its frame; each clock presents the next queued bit.
  initial begin
    cur0 = '0;
    cur1 = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        cur0 = '0;
        cur1 = '0;
      end else begin
        if (v0 && (!cur0.v || cur0.en)) push_frame(0, din0, 1'b1);
        if (v1 && (!cur1.v || cur1.en)) push_frame(1, din1, 1'b0);
        if (q0.size() > 0) cur0 = q0.pop_front(); else cur0 = '0;
        if (q1.size() > 0) cur1 = q1.pop_front(); else cur1 = '0;
      end
    end
  end

  task automatic chk_inst(input int k, input ebit_t e);
    check($sformatf("x%0d", k),     32'(xo[k]),  32'(e.x));
    check($sformatf("xv%0d", k),    32'(xv[k]),  32'(e.v));
    check($sformatf("start%0d", k), 32'(fs[k]),  32'(e.st));
    check($sformatf("end%0d", k),   32'(fe[k]),  32'(e.en));
    check($sformatf("busy%0d", k),  32'(bz[k]),  32'(e.v));
    check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(rst_n && (!e.v || e.en)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk_inst(0, cur0);
      chk_inst(1, cur1);
    end
  end

  task automatic send(input int k, input logic [W-1:0] w, input bit keep);
    logic r;
    bit   done = 1'b0;
    if (k == 0) begin din0 = w; v0 = 1'b1; end
    else        begin din1 = w; v1 = 1'b1; end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = rdy[k];
      @(posedge clk);
      #2;
      if (r) done = 1'b1;
    end
    if (!keep) begin
      if (k == 0) v0 = 1'b0; else v1 = 1'b0;
    end
    check($sformatf("handshake%0d", k), 32'(done), 32'd1);
  endtask

  task automatic collect(input int k, input int n, output logic [31:0] s, output logic [31:0] b);
    s = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s[i] = xo[k];
      b[i] = bz[k];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, b;
    logic [1:0]  r;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_xv", 32'(xv), 32'd0);
    check("reset_busy", 32'(bz), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    check("pin_lsb_a5", 32'(frame_word(8'hA5, 1'b1)), 32'hA5);
    check("pin_msb_80", 32'(frame_word(8'h80, 1'b0)), 32'h01);
    check("pin_par_a5", 32'(par_of(8'hA5)), 32'd0);
    check("pin_par_07", 32'(par_of(8'h07)), 32'd1);

    send(0, 8'hA5, 1'b0);
    collect(0, NF, s, b);
    check("a5_seq", s, 32'hA5);
    check("a5_busy", b, 32'((1 << NF) - 1));
    @(negedge clk);
    check("a5_idle_after", 32'(xv[0]), 32'd0);

    @(posedge clk); #2;
    send(0, 8'h07, 1'b0);
    collect(0, NF, s, b);
    check("07_seq", s, (PAR != 0) ? 32'h107 : 32'h07);

    @(posedge clk); #2;
    send(1, 8'h80, 1'b0);
    din1 = 8'h00;
    collect(1, NF, s, b);
    check("msb_80_seq", s, (PAR != 0) ? 32'h101 : 32'h01);

    @(posedge clk); #2;
    send(0, 8'hFF, 1'b1);
    fork
      send(0, 8'h01, 1'b0);
      collect(0, 2 * NF, s, b);
    join
    check("b2b_seq", s, (PAR != 0) ? 32'h202FF : 32'h01FF);
    check("b2b_busy", b, 32'((1 << (2 * NF)) - 1));

    @(posedge clk); #2;
    send(0, 8'hC3, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_x", 32'(xo), 32'd0);
    check("midrst_xv", 32'(xv), 32'd0);
    check("midrst_busy", 32'(bz), 32'd0);
    check("midrst_ready", 32'(rdy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(0, 8'h3C, 1'b0);
    collect(0, NF, s, b);
    check("3c_seq", s, 32'h3C);

    @(posedge clk); #2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = rdy;
      @(posedge clk);
      #2;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (!v0 || r[0]) begin
        v0   = ($urandom_range(0, 3) != 0);
        din0 = W'($urandom);
      end
      if (!v1 || r[1]) begin
        v1   = ($urandom_range(0, 3) != 0);
        din1 = W'($urandom);
      end
    end
    rst_n = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2 * NF + 4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
